instruction_fetch: RTL and testbench

Instruction fetch stage, directly upstream of `instruction_decode`. It owns the program counter and issues word-aligned requests to instruction memory over a valid/ready request channel. It accepts in-order responses that cannot be back-pressured and buffers them in a small FIFO. It delivers `{pc, instruction}` pairs to decode over a valid/ready handshake, and supports redirects (branch/jump/trap) with flush of buffered and in-flight fetches.

---
 rtl/common_pkg.sv | 9 +
 rtl/fetch_fifo.sv | 59 +++++
 rtl/instruction_fetch.sv | 86 ++++++++
 tb/tb_instruction_fetch.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/common_pkg.sv
// Shared fetch types: the buffered {pc, instruction} entry and the PC increment.
package common;
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] data;
   } fetch_entry_t;

   localparam logic [31:0] PC_STEP = 32'd4;
endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: synchronous FIFO of fetch entries with flush.
// The head entry is read straight from storage so it is register-driven.
module fetch_fifo
   import common::*;
#(
   parameter int DEPTH = 2,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  fetch_entry_t  push_data,
   input  logic          pop,
   input  logic          flush,
   output fetch_entry_t  head,
   output logic [CW-1:0] occupancy
);
   fetch_entry_t [DEPTH-1:0] mem_q, mem_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      // Flush wins over a simultaneous push/pop; storage is left as-is.
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
         end
         if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign head      = mem_q[rd_ptr_q];
   assign occupancy = count_q;
endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues credit-limited memory requests, buffers
// in-order responses and hands {pc, instruction} to decode; redirects flush.
module instruction_fetch
   import common::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr_data,
   output logic [31:0] instr_pc
);
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   logic [31:0]   fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d, redirect_target;
   logic [CW-1:0] outstanding_q, outstanding_d, drop_q, drop_d, occupancy;
   logic          pop, credit, accept, discard, push;
   fetch_entry_t  head;

   assign redirect_target = redirect_pc & 32'hFFFF_FFFC;
   assign instr_valid     = (occupancy != '0);
   assign pop             = instr_valid & instr_ready;

   // Every in-flight request must already own a FIFO slot when it returns.
   assign credit = (int'(outstanding_q) + int'(occupancy) - int'(pop)) < FIFO_DEPTH;
   assign imem_req_valid = credit & ~redirect_valid & ~rst;
   assign imem_req_addr  = fetch_pc_q;
   assign accept         = imem_req_valid & imem_req_ready;

   assign discard = imem_rsp_valid & (redirect_valid | (drop_q != '0));
   assign push    = imem_rsp_valid & ~discard;

   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      rsp_pc_d      = rsp_pc_q;
      drop_d        = drop_q;
      outstanding_d = outstanding_q + CW'(accept) - CW'(imem_rsp_valid);
      if (accept) fetch_pc_d = fetch_pc_q + PC_STEP;
      if (push) rsp_pc_d = rsp_pc_q + PC_STEP;
      if (imem_rsp_valid && drop_q != '0) drop_d = drop_q - CW'(1);
      // Everything still in flight belongs to the old stream.
      if (redirect_valid) begin
         fetch_pc_d = redirect_target;
         rsp_pc_d   = redirect_target;
         drop_d     = outstanding_q - CW'(imem_rsp_valid);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc_q    <= RESET_PC;
         rsp_pc_q      <= RESET_PC;
         outstanding_q <= '0;
         drop_q        <= '0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         rsp_pc_q      <= rsp_pc_d;
         outstanding_q <= outstanding_d;
         drop_q        <= drop_d;
      end
   end

   fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data ('{pc: rsp_pc_q, data: imem_rsp_data}),
      .pop       (pop),
      .flush     (redirect_valid),
      .head      (head),
      .occupancy (occupancy)
   );

   assign instr_data = head.data;
   assign instr_pc   = head.pc;
endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a fixed-latency in-order memory model.
module tb_instruction_fetch;
   logic        clk, rst;
   logic        imem_req_valid, imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        instr_valid, instr_ready;
   logic [31:0] instr_data, instr_pc;

   int errors = 0;
   int checks = 0;
   int lat    = 1;
   int cyc    = 0;

   typedef struct { logic [31:0] a; int due; } mreq_t;
   mreq_t mq[$];

   instruction_fetch dut (
      .clk(clk), .rst(rst),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr_data(instr_data), .instr_pc(instr_pc)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mdata(input logic [31:0] a);
      return a ^ 32'hA5C3_5A3C;
   endfunction

   // Memory: accepted request answered exactly lat cycles later.
   always @(posedge clk or posedge rst) begin
      if (rst) mq.delete();
      else begin
         if (imem_req_valid && imem_req_ready) mq.push_back(mreq_t'{imem_req_addr, cyc + lat});
         cyc++;
      end
   end

   always @(negedge clk) begin
      imem_rsp_valid = 0;
      imem_rsp_data  = 32'h0;
      if (!rst && mq.size() > 0 && mq[0].due == cyc) begin
         imem_rsp_valid = 1;
         imem_rsp_data  = mdata(mq[0].a);
         void'(mq.pop_front());
      end
   end

   task automatic do_reset(input logic drdy, input logic mrdy, input int l);
      rst = 1; redirect_valid = 0; redirect_pc = 0;
      instr_ready = drdy; imem_req_ready = mrdy; lat = l;
      repeat (2) @(negedge clk);
      rst = 0;
   endtask

   task automatic test_reset();
      rst = 1; redirect_valid = 0; redirect_pc = 0; instr_ready = 1; imem_req_ready = 1; lat = 1;
      repeat (3) @(negedge clk);
      #1;
      checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b want 0", imem_req_valid); end
      checks++; if (imem_req_addr !== 32'h0) begin errors++; $display("FAIL reset_req_addr: got %h want 0", imem_req_addr); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_instr_valid: got %b want 0", instr_valid); end
      checks++; if (instr_data !== 32'h0) begin errors++; $display("FAIL reset_instr_data: got %h want 0", instr_data); end
      checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL reset_instr_pc: got %h want 0", instr_pc); end
      @(negedge clk); rst = 0; #1;
      checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL reset_first_req: got %b want 1", imem_req_valid); end
   endtask

   task automatic test_stream();
      do_reset(1, 1, 1);
      for (int k = 0; k < 6; k++) begin
         if (k > 0) @(negedge clk);
         #1;
         checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'(4*k)) begin errors++;
            $display("FAIL stream_req k=%0d: got v=%b a=%h want v=1 a=%h", k, imem_req_valid, imem_req_addr, 32'(4*k)); end
         if (k >= 2) begin
            checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'(4*(k-2)) || instr_data !== mdata(32'(4*(k-2)))) begin errors++;
               $display("FAIL stream_instr k=%0d: got v=%b pc=%h d=%h want pc=%h", k, instr_valid, instr_pc, instr_data, 32'(4*(k-2))); end
         end else begin
            checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL stream_early k=%0d: got %b want 0", k, instr_valid); end
         end
      end
   endtask

   task automatic test_backpressure();
      do_reset(0, 1, 1);
      for (int k = 0; k < 5; k++) begin
         if (k > 0) @(negedge clk);
         #1;
         checks++; if (imem_req_valid !== (k < 2)) begin errors++;
            $display("FAIL bp_req_valid k=%0d: got %b want %b", k, imem_req_valid, k < 2); end
      end
      checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin errors++;
         $display("FAIL bp_head: got v=%b pc=%h want v=1 pc=0", instr_valid, instr_pc); end
      @(negedge clk); instr_ready = 1; #1;
      checks++; if (instr_pc !== 32'h0 || instr_data !== mdata(32'h0)) begin errors++;
         $display("FAIL bp_pop0: got pc=%h d=%h want pc=0", instr_pc, instr_data); end
      checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8) begin errors++;
         $display("FAIL bp_req8: got v=%b a=%h want v=1 a=8", imem_req_valid, imem_req_addr); end
      @(negedge clk); #1;
      checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h4 || instr_data !== mdata(32'h4)) begin errors++;
         $display("FAIL bp_pop4: got v=%b pc=%h d=%h want pc=4", instr_valid, instr_pc, instr_data); end
   endtask

   task automatic test_req_stall();
      do_reset(1, 0, 1);
      for (int k = 0; k < 4; k++) begin
         if (k > 0) @(negedge clk);
         if (k == 3) imem_req_ready = 1;
         #1;
         checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin errors++;
            $display("FAIL stall_req k=%0d: got v=%b a=%h want v=1 a=0", k, imem_req_valid, imem_req_addr); end
      end
      @(negedge clk); #1;
      checks++; if (imem_req_addr !== 32'h4) begin errors++; $display("FAIL stall_next: got %h want 4", imem_req_addr); end
      @(negedge clk); #1;
      checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin errors++;
         $display("FAIL stall_instr: got v=%b pc=%h want v=1 pc=0", instr_valid, instr_pc); end
   endtask

   task automatic test_redirect_drop();
      bit found;
      do_reset(1, 1, 3);
      @(negedge clk); @(negedge clk);
      redirect_valid = 1; redirect_pc = 32'h103; #1;
      checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rd_req_in_R: got %b want 0", imem_req_valid); end
      @(negedge clk); redirect_valid = 0; #1;
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rd_instr_R1: got %b want 0", instr_valid); end
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (imem_req_valid) found = 1;
         else begin @(negedge clk); #1; end
      end
      checks++; if (!found || imem_req_addr !== 32'h100) begin errors++;
         $display("FAIL rd_new_req: got found=%b a=%h want a=100", found, imem_req_addr); end
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (instr_valid) found = 1;
         else begin @(negedge clk); #1; end
      end
      checks++; if (!found || instr_pc !== 32'h100 || instr_data !== mdata(32'h100)) begin errors++;
         $display("FAIL rd_first_instr: got found=%b pc=%h d=%h want pc=100 d=%h", found, instr_pc, instr_data, mdata(32'h100)); end
   endtask

   task automatic test_redirect_wrap();
      logic [31:0] ea [4] = '{32'hFFFF_FFFC, 32'h0, 32'h4, 32'h8};
      do_reset(1, 1, 1);
      repeat (3) @(negedge clk);
      redirect_valid = 1; redirect_pc = 32'hFFFF_FFFC; #1;
      checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL wrap_req_in_R: got %b want 0", imem_req_valid); end
      for (int k = 0; k < 4; k++) begin
         @(negedge clk); redirect_valid = 0; #1;
         checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== ea[k]) begin errors++;
            $display("FAIL wrap_req k=%0d: got v=%b a=%h want %h", k, imem_req_valid, imem_req_addr, ea[k]); end
         if (k < 2) begin
            checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL wrap_instr_gap k=%0d: got %b want 0", k, instr_valid); end
         end else begin
            checks++; if (instr_valid !== 1'b1 || instr_pc !== ea[k-2] || instr_data !== mdata(ea[k-2])) begin errors++;
               $display("FAIL wrap_instr k=%0d: got v=%b pc=%h want pc=%h", k, instr_valid, instr_pc, ea[k-2]); end
         end
      end
   endtask

   task automatic test_reset_mid();
      do_reset(0, 1, 1);
      repeat (5) @(negedge clk);
      #1;
      checks++; if (instr_valid !== 1'b1 || imem_req_valid !== 1'b0) begin errors++;
         $display("FAIL mid_full: got iv=%b rv=%b want iv=1 rv=0", instr_valid, imem_req_valid); end
      #2; rst = 1; #1;
      checks++; if (instr_valid !== 1'b0 || instr_data !== 32'h0 || instr_pc !== 32'h0) begin errors++;
         $display("FAIL mid_async_instr: got v=%b d=%h pc=%h want 0", instr_valid, instr_data, instr_pc); end
      checks++; if (imem_req_valid !== 1'b0 || imem_req_addr !== 32'h0) begin errors++;
         $display("FAIL mid_async_req: got v=%b a=%h want v=0 a=0", imem_req_valid, imem_req_addr); end
      @(negedge clk); instr_ready = 1; rst = 0; #1;
      checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin errors++;
         $display("FAIL mid_restart: got v=%b a=%h want v=1 a=0", imem_req_valid, imem_req_addr); end
      repeat (2) @(negedge clk);
      #1;
      checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr_data !== mdata(32'h0)) begin errors++;
         $display("FAIL mid_first_instr: got v=%b pc=%h d=%h want pc=0", instr_valid, instr_pc, instr_data); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      imem_rsp_valid = 0; imem_rsp_data = 0;
      test_reset();
      test_stream();
      test_backpressure();
      test_req_stall();
      test_redirect_drop();
      test_redirect_wrap();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
